mr1_mem_arbiter: RTL and testbench
==================================

# mr1_mem_arbiter

Two-requester memory-port arbiter for the MR1 core. It merges the instruction-fetch port (instr_req/instr_rsp) and the data port (data_req/data_rsp) onto one shared in-order memory port. Data has priority, with a bounded starvation guard for fetch. Response routing uses an owner FIFO of outstanding reads. It sits between MR1 and the single-ported memory/bus model in both the SoC and the formal harness.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: max accepted-but-unanswered reads; power of two, ≥1.
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits; ≥1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_req_valid  in  1  fetch request.
- instr_req_ready  out  1  fetch request accepted this cycle.
- instr_req_addr  in  32  fetch address.
- instr_rsp_valid  out  1  fetch read data valid.
- instr_rsp_data  out  32  fetch read data.
- data_req_valid  in  1  load/store request.
- data_req_ready  out  1  data request accepted this cycle.
- data_req_addr  in  32  data address.
- data_req_wr  in  1  1 = store (no response), 0 = load.
- data_req_size  in  2  0 = byte, 1 = half, 2 = word.
- data_req_data  in  32  store data.
- data_rsp_valid  out  1  load data valid.
- data_rsp_data  out  32  load data.
- mem_req_valid  out  1  shared request.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr / mem_req_wr / mem_req_size / mem_req_data  out  32/1/2/32  muxed payload; fetch drives wr=0, size=2, data=0.
- mem_rsp_valid  in  1  in-order read response.
- mem_rsp_data  in  32  read data.
- pending  out  $clog2(MAX_OUTSTANDING+1)  owner-FIFO occupancy.
- rsp_err  out  1  sticky: response arrived with empty FIFO.

## Operation
- Owner FIFO: MAX_OUTSTANDING entries of 1 bit (0 = instr, 1 = data). Push on an accepted fetch or load. Stores do not push. Pop on mem_rsp_valid.
- full = (pending == MAX_OUTSTANDING). While full, no new grant: mem_req_valid = 0 unless a request is locked, and both readies are 0. A pop in the same cycle does not unblock; there is no bypass.
- Lock: if mem_req_valid && !mem_req_ready, register lock = 1 and lock_owner = current owner. While locked, the owner is held regardless of the other requester. Lock clears on handshake. A locked request was granted while not full, so full never drops it.
- Selection when unlocked and not full:
  - Only one requester valid: that requester.
  - Both valid: data, unless streak == STARVE_LIMIT, in which case instr.
- streak counter, saturating at STARVE_LIMIT:
  - +1 on each data handshake while instr_req_valid = 1.
  - Cleared on an instr handshake or on any cycle with instr_req_valid = 0.
- Selected requester: its ready = mem_req_ready. The other requester's ready = 0. Payload is muxed combinationally.
- Response routing: instr_rsp_valid = mem_rsp_valid && !empty && head == 0; data_rsp_valid = mem_rsp_valid && !empty && head == 1. Both rsp_data = mem_rsp_data.
- mem_rsp_valid while empty: no pop, no rsp_valid, rsp_err <= 1. rsp_err clears only on reset.
- Simultaneous push and pop: pending is unchanged and both pointers advance.
- Requesters hold valid and payload stable until ready.

## Timing
- Request path is combinational, 0 cycles from requester valid to mem_req_valid. Response path is combinational, 0 cycles.
- FIFO, pending, lock, streak and rsp_err update on the rising clock edge.
- mem_rsp for a request arrives ≥1 cycle after its accept edge. A response in the same cycle as its own acceptance sees the pre-push FIFO state.
- Reset (async, any time): pending = 0, pointers = 0, lock = 0, streak = 0, rsp_err = 0.
  - Outputs are then combinational from inputs with empty FIFO: readies follow mem_req_ready for the selected requester, rsp_valids = 0.
  - Responses to requests accepted before reset set rsp_err.

## Test plan
- Fetch only, memory ready, 1-cycle response latency, addr 0x0,0x4,0x8: three mem handshakes with wr=0, size=2; instr_rsp_valid returns the three data words in order; pending peaks at 1.
- Both requesters valid continuously, all loads, STARVE_LIMIT=4: grant order D,D,D,D,I,D,D,D,D,I; the streak resets after each I.
- mem_req_ready = 0 for 3 cycles with instr locked, then data_req_valid rises: instr stays granted with mem_req_addr unchanged; data is granted the cycle after the instr handshake.
- Four loads accepted with no response (MAX_OUTSTANDING=4): pending = 4, both readies 0; one mem_rsp_valid then pending = 3 and grants resume the next cycle; a store does not raise pending.
- Interleaved I,D,I reads, responses 0xA,0xB,0xC: instr gets 0xA and 0xC, data gets 0xB, never both valid in one cycle.
- mem_rsp_valid with pending = 0, then assert reset with 2 pending: rsp_err = 1, then pending = 0 and rsp_err = 0 during reset.

Source files
------------

// File: rtl/mr1_mem_arbiter_if.sv
// mr1_mem_arbiter_if
//   Bundles the three handshake ports of the MR1 memory arbiter:
//   instruction fetch (instr_req/instr_rsp), data load/store (data_req/data_rsp)
//   and the shared in-order memory port (mem_req/mem_rsp).
//   slave  : arbiter side (accepts requester traffic, drives the memory port)
//   master : environment side (requesters plus memory model)
interface mr1_mem_arbiter_if;
    logic        instr_req_valid;
    logic        instr_req_ready;
    logic [31:0] instr_req_addr;
    logic        instr_rsp_valid;
    logic [31:0] instr_rsp_data;

    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_req_addr;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  instr_req_valid, instr_req_addr,
        input  data_req_valid, data_req_addr, data_req_wr, data_req_size, data_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_req_ready, instr_rsp_valid, instr_rsp_data,
        output data_req_ready, data_rsp_valid, data_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wr, mem_req_size, mem_req_data
    );

    modport master (
        output instr_req_valid, instr_req_addr,
        output data_req_valid, data_req_addr, data_req_wr, data_req_size, data_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
        input  data_req_ready, data_rsp_valid, data_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wr, mem_req_size, mem_req_data
    );
endinterface

// File: rtl/mr1_mem_arbiter.sv
// mr1_mem_arbiter
//   Merges the MR1 fetch port and data port onto one shared in-order memory
//   port. Data wins ties unless fetch has waited through STARVE_LIMIT data
//   grants. An owner FIFO of outstanding reads routes responses back.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous, active-high
//   bus      - handshake bundle (slave side): instr_*, data_*, mem_*
//   pending  - owner-FIFO occupancy (accepted, unanswered reads)
//   rsp_err  - sticky flag: a memory response arrived with no read outstanding
module mr1_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    mr1_mem_arbiter_if.slave                     bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pending,
    output logic                                 rsp_err
);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    // Lock state doubles as the held owner while memory stalls a request.
    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCK_INSTR,
        ST_LOCK_DATA
    } state_t;

    state_t state, state_nxt;

    logic                owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [STREAK_W-1:0] streak;

    logic full, empty, head;
    logic sel_instr, sel_data, grant_valid;
    logic hs_instr, hs_data, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (pending == CNT_FULL);
    assign empty = (pending == '0);
    assign head  = owner_q[rd_ptr];

    // Owner selection and lock next-state. A locked owner is granted even when
    // full: it was accepted into arbitration before the FIFO filled.
    always_comb begin
        sel_instr = 1'b0;
        sel_data  = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_LOCK_INSTR: sel_instr = 1'b1;
            ST_LOCK_DATA:  sel_data  = 1'b1;
            default: begin
                if (!full) begin
                    if (bus.data_req_valid && (!bus.instr_req_valid || streak != STREAK_MAX))
                        sel_data = 1'b1;
                    else if (bus.instr_req_valid)
                        sel_instr = 1'b1;
                end
            end
        endcase
        grant_valid = (sel_instr && bus.instr_req_valid) || (sel_data && bus.data_req_valid);
        if (grant_valid && !bus.mem_req_ready)
            state_nxt = sel_instr ? ST_LOCK_INSTR : ST_LOCK_DATA;
        else if (grant_valid)
            state_nxt = ST_OPEN;
    end

    assign bus.mem_req_valid   = grant_valid;
    assign bus.mem_req_addr    = sel_instr ? bus.instr_req_addr : bus.data_req_addr;
    assign bus.mem_req_wr      = sel_instr ? 1'b0 : bus.data_req_wr;
    assign bus.mem_req_size    = sel_instr ? 2'd2 : bus.data_req_size;
    assign bus.mem_req_data    = sel_instr ? '0 : bus.data_req_data;
    assign bus.instr_req_ready = sel_instr && bus.mem_req_ready;
    assign bus.data_req_ready  = sel_data && bus.mem_req_ready;

    assign hs_instr = sel_instr && bus.instr_req_valid && bus.mem_req_ready;
    assign hs_data  = sel_data && bus.data_req_valid && bus.mem_req_ready;
    assign push     = hs_instr || (hs_data && !bus.data_req_wr);
    assign pop      = bus.mem_rsp_valid && !empty;

    assign bus.instr_rsp_valid = pop && !head;
    assign bus.data_rsp_valid  = pop && head;
    assign bus.instr_rsp_data  = bus.mem_rsp_data;
    assign bus.data_rsp_data   = bus.mem_rsp_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_OPEN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            streak  <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                pending <= pending + CNT_W'(1);
            else if (pop && !push)
                pending <= pending - CNT_W'(1);
            if (bus.mem_rsp_valid && empty)
                rsp_err <= 1'b1;
            // Streak counts data wins only while fetch is actually waiting.
            if (!bus.instr_req_valid || hs_instr)
                streak <= '0;
            else if (hs_data && streak != STREAK_MAX)
                streak <= streak + STREAK_W'(1);
        end
    end

    // Owner storage needs no reset: entries are only read behind the pointers.
    always_ff @(posedge clock) begin
        if (push) owner_q[wr_ptr] <= hs_data;
    end
endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// tb_mr1_mem_arbiter
//   Scoreboard bench: expected read data is queued per requester when the
//   memory handshake is observed and compared when the response is routed.
module tb_mr1_mem_arbiter;
    logic       clock;
    logic       reset;
    logic [2:0] pending;
    logic       rsp_err;

    mr1_mem_arbiter_if bus ();

    mr1_mem_arbiter #(
        .MAX_OUTSTANDING(4),
        .STARVE_LIMIT(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .pending (pending),
        .rsp_err (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_i_q [$];
    logic [31:0] exp_d_q [$];
    logic [31:0] mem_q   [$];
    byte         grant_log [$];
    int          rx_instr = 0;
    int          rx_data  = 0;
    int          peak     = 0;

    bit rsp_hold      = 1'b0;
    int sent_count    = 0;
    int release_limit = 0;
    int inject_req    = 0;
    int inject_done   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h500: return 32'hA;
            32'h504: return 32'hB;
            32'h508: return 32'hC;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory model: answers reads one cycle after acceptance unless held.
    initial begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            #2;
            if (mem_q.size() > 0 && (!rsp_hold || sent_count < release_limit)) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_q.pop_front();
                sent_count++;
            end else if (inject_req != inject_done) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = 32'hDEAD_BEEF;
                inject_done++;
            end else begin
                bus.mem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mem_rsp_valid)
                check("rsp_onehot", {31'd0, bus.instr_rsp_valid & bus.data_rsp_valid}, 32'd0);
            if (bus.instr_rsp_valid) begin
                if (exp_i_q.size() == 0) check("instr_rsp_spurious", {31'd0, bus.instr_rsp_valid}, 32'd0);
                else begin
                    check("instr_rsp_data", bus.instr_rsp_data, exp_i_q.pop_front());
                    rx_instr++;
                end
            end
            if (bus.data_rsp_valid) begin
                if (exp_d_q.size() == 0) check("data_rsp_spurious", {31'd0, bus.data_rsp_valid}, 32'd0);
                else begin
                    check("data_rsp_data", bus.data_rsp_data, exp_d_q.pop_front());
                    rx_data++;
                end
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                check("ready_onehot", {31'd0, bus.instr_req_ready & bus.data_req_ready}, 32'd0);
                if (bus.instr_req_ready) begin
                    grant_log.push_back(8'h49);
                    check("i_addr", bus.mem_req_addr, bus.instr_req_addr);
                    check("i_wr", {31'd0, bus.mem_req_wr}, 32'd0);
                    check("i_size", {30'd0, bus.mem_req_size}, 32'd2);
                    check("i_wdata", bus.mem_req_data, 32'd0);
                    exp_i_q.push_back(mem_word(bus.instr_req_addr));
                    mem_q.push_back(mem_word(bus.mem_req_addr));
                end else if (bus.data_req_ready) begin
                    grant_log.push_back(8'h44);
                    check("d_addr", bus.mem_req_addr, bus.data_req_addr);
                    check("d_wr", {31'd0, bus.mem_req_wr}, {31'd0, bus.data_req_wr});
                    check("d_size", {30'd0, bus.mem_req_size}, {30'd0, bus.data_req_size});
                    check("d_wdata", bus.mem_req_data, bus.data_req_data);
                    if (!bus.data_req_wr) begin
                        exp_d_q.push_back(mem_word(bus.data_req_addr));
                        mem_q.push_back(mem_word(bus.mem_req_addr));
                    end
                end else begin
                    check("hs_no_owner", {31'd0, bus.instr_req_ready | bus.data_req_ready}, 32'd1);
                end
            end
            if (int'(pending) > peak) peak = int'(pending);
        end
    end

    task automatic wait_hs(input bit is_instr, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            seen = is_instr ? (bus.instr_req_valid && bus.instr_req_ready)
                            : (bus.data_req_valid && bus.data_req_ready);
        end
        check(tag, {31'd0, seen}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            done = (pending == 3'd0);
        end
        check(tag, {29'd0, pending}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.instr_req_valid = 1'b1;
        bus.instr_req_addr  = a;
        wait_hs(1'b1, "fetch_hs");
        bus.instr_req_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        bus.data_req_valid = 1'b1;
        bus.data_req_addr  = a;
        bus.data_req_wr    = 1'b0;
        bus.data_req_size  = 2'd2;
        bus.data_req_data  = '0;
        wait_hs(1'b0, "load_hs");
        bus.data_req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    ri, rd, gstart;
        bit    hi, hd;
        string exp_order;
        logic [31:0] iaddr, daddr, gc;

        reset = 1'b1;
        bus.instr_req_valid = 1'b0;
        bus.instr_req_addr  = '0;
        bus.data_req_valid  = 1'b0;
        bus.data_req_addr   = '0;
        bus.data_req_wr     = 1'b0;
        bus.data_req_size   = 2'd0;
        bus.data_req_data   = '0;
        bus.mem_req_ready   = 1'b0;

        // Reset state and combinational request path during reset
        @(negedge clock);
        check("rst_pending", {29'd0, pending}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mvalid", {31'd0, bus.mem_req_valid}, 32'd0);
        bus.instr_req_valid = 1'b1;
        bus.instr_req_addr  = 32'h40;
        bus.mem_req_ready   = 1'b1;
        #1;
        check("rst_iready", {31'd0, bus.instr_req_ready}, 32'd1);
        check("rst_dready", {31'd0, bus.data_req_ready}, 32'd0);
        check("rst_mvalid2", {31'd0, bus.mem_req_valid}, 32'd1);
        check("rst_maddr", bus.mem_req_addr, 32'h40);
        bus.instr_req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fetch-only stream
        ri = rx_instr;
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        wait_drain("fetch_drain");
        check("fetch_rx", ri + 3, rx_instr);
        check("fetch_peak", peak, 32'd1);

        // Starvation guard: both valid, all loads
        iaddr = 32'h1000;
        daddr = 32'h2000;
        bus.instr_req_valid = 1'b1;
        bus.instr_req_addr  = iaddr;
        bus.data_req_valid  = 1'b1;
        bus.data_req_addr   = daddr;
        bus.data_req_wr     = 1'b0;
        bus.data_req_size   = 2'd2;
        bus.data_req_data   = '0;
        gstart = grant_log.size();
        for (int c = 0; c < 60 && grant_log.size() < gstart + 10; c++) begin
            @(negedge clock);
            hi = bus.instr_req_valid && bus.instr_req_ready;
            hd = bus.data_req_valid && bus.data_req_ready;
            @(posedge clock);
            #1;
            if (hi) iaddr += 4;
            if (hd) daddr += 4;
            bus.instr_req_addr = iaddr;
            bus.data_req_addr  = daddr;
        end
        bus.instr_req_valid = 1'b0;
        bus.data_req_valid  = 1'b0;
        exp_order = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            gc = (gstart + i < grant_log.size()) ? {24'd0, grant_log[gstart + i]} : 32'd0;
            check("grant_order", gc, {24'd0, exp_order[i]});
        end
        wait_drain("starve_drain");

        // Lock: fetch stalled by memory, data arrives later
        bus.mem_req_ready   = 1'b0;
        bus.instr_req_valid = 1'b1;
        bus.instr_req_addr  = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("lock_mvalid", {31'd0, bus.mem_req_valid}, 32'd1);
            check("lock_addr", bus.mem_req_addr, 32'h100);
            check("lock_iready", {31'd0, bus.instr_req_ready}, 32'd0);
            @(posedge clock);
            #1;
        end
        bus.data_req_valid = 1'b1;
        bus.data_req_addr  = 32'h200;
        bus.data_req_wr    = 1'b0;
        bus.data_req_size  = 2'd2;
        @(negedge clock);
        check("lock_hold_addr", bus.mem_req_addr, 32'h100);
        check("lock_dready", {31'd0, bus.data_req_ready}, 32'd0);
        @(posedge clock);
        #1;
        bus.mem_req_ready = 1'b1;
        @(negedge clock);
        check("lock_i_hs", {31'd0, bus.instr_req_ready}, 32'd1);
        check("lock_i_addr", bus.mem_req_addr, 32'h100);
        @(posedge clock);
        #1;
        bus.instr_req_valid = 1'b0;
        @(negedge clock);
        check("lock_d_next", {31'd0, bus.data_req_ready}, 32'd1);
        check("lock_d_addr", bus.mem_req_addr, 32'h200);
        @(posedge clock);
        #1;
        bus.data_req_valid = 1'b0;
        wait_drain("lock_drain");

        // Full FIFO blocks grants; a same-cycle pop does not bypass
        rsp_hold = 1'b1;
        load(32'h300);
        load(32'h304);
        load(32'h308);
        load(32'h30C);
        bus.data_req_valid = 1'b1;
        bus.data_req_addr  = 32'h310;
        @(negedge clock);
        check("full_pending", {29'd0, pending}, 32'd4);
        check("full_dready", {31'd0, bus.data_req_ready}, 32'd0);
        check("full_iready", {31'd0, bus.instr_req_ready}, 32'd0);
        check("full_mvalid", {31'd0, bus.mem_req_valid}, 32'd0);
        @(posedge clock);
        #1;
        release_limit = sent_count + 1;
        @(negedge clock);
        check("full_nobypass", {31'd0, bus.data_req_ready}, 32'd0);
        check("full_pend_pop", {29'd0, pending}, 32'd4);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("full_resume_pend", {29'd0, pending}, 32'd3);
        check("full_resume", {31'd0, bus.data_req_ready}, 32'd1);
        @(posedge clock);
        #1;
        bus.data_req_valid = 1'b0;
        rsp_hold = 1'b0;
        wait_drain("full_drain");

        // Store does not occupy the owner FIFO
        bus.data_req_valid = 1'b1;
        bus.data_req_addr  = 32'h400;
        bus.data_req_wr    = 1'b1;
        bus.data_req_size  = 2'd0;
        bus.data_req_data  = 32'h1234_5678;
        wait_hs(1'b0, "store_hs");
        bus.data_req_valid = 1'b0;
        bus.data_req_wr    = 1'b0;
        @(negedge clock);
        check("store_pending", {29'd0, pending}, 32'd0);
        @(posedge clock);
        #1;

        // Interleaved I,D,I with back-to-back responses
        ri = rx_instr;
        rd = rx_data;
        rsp_hold = 1'b1;
        fetch(32'h500);
        load(32'h504);
        fetch(32'h508);
        @(negedge clock);
        check("ileave_pending", {29'd0, pending}, 32'd3);
        @(posedge clock);
        #1;
        rsp_hold = 1'b0;
        wait_drain("ileave_drain");
        check("ileave_icount", rx_instr - ri, 32'd2);
        check("ileave_dcount", rx_data - rd, 32'd1);

        // Spurious response, then reset with reads outstanding
        inject_req++;
        @(negedge clock);
        check("spur_ivalid", {31'd0, bus.instr_rsp_valid}, 32'd0);
        check("spur_dvalid", {31'd0, bus.data_rsp_valid}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("spur_err", {31'd0, rsp_err}, 32'd1);
        check("spur_pending", {29'd0, pending}, 32'd0);
        @(posedge clock);
        #1;
        rsp_hold = 1'b1;
        fetch(32'h600);
        fetch(32'h604);
        @(negedge clock);
        check("pre_rst_pending", {29'd0, pending}, 32'd2);
        check("pre_rst_err", {31'd0, rsp_err}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pending", {29'd0, pending}, 32'd0);
        check("arst_err", {31'd0, rsp_err}, 32'd0);
        check("arst_ivalid", {31'd0, bus.instr_rsp_valid}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_err", {31'd0, rsp_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
